// File: rtl/aes_pkg.sv
// Shared AES-128 arithmetic: S-box, Rcon, GF(2^8) multiply helpers, byte swap.
package aes_pkg;

   localparam int unsigned AES_NR = 10;

   // Forward S-box, entry 0 at the most significant byte.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[x];
   endfunction

   // Round constant for the expansion step that produces round key r (1..10).
   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul2(input logic [7:0] b);
      return xtime(b);
   endfunction

   function automatic logic [7:0] gmul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

   // Converts between MSB-first (FIPS) and LSB-first byte order.
   function automatic logic [127:0] bswap(input logic [127:0] x);
      logic [127:0] y;
      y = '0;
      for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
      return y;
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// One combinational AES-128 key expansion step (FIPS byte order, byte 0 at [127:120]).
//   key      in  128  current round key
//   rcon     in  8    round constant for the key being produced
//   key_next out 128  following round key
module aes_key_step
   import aes_pkg::*;
(
   input  logic [127:0] key,
   input  logic [7:0]   rcon,
   output logic [127:0] key_next
);

   logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
   logic [31:0] rot_w3;
   logic [31:0] sub_rot;

   assign w0 = key[127:96];
   assign w1 = key[95:64];
   assign w2 = key[63:32];
   assign w3 = key[31:0];

   assign rot_w3  = {w3[23:0], w3[31:24]};
   assign sub_rot = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                     sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])};

   // Rcon only touches the leading byte of the word.
   assign w4 = w0 ^ sub_rot ^ {rcon, 24'h000000};
   assign w5 = w1 ^ w4;
   assign w6 = w2 ^ w5;
   assign w7 = w3 ^ w6;

   assign key_next = {w4, w5, w6, w7};

endmodule

// File: rtl/aes_round_engine.sv
// AES-128 datapath: registered cipher round plus on-the-fly round-key generator.
// Optional trace output when AES_TRACE_EN is defined (function unchanged).
//   clk, rst_n          clock, async active-low reset
//   load, next, key_in  key schedule control and cipher key (FIPS byte order)
//   key_out, round      current round key (FIPS byte order) and its index 0..10
//   en, skip_mixcols    round capture enable, final-round MixColumns bypass
//   state_in, round_key round inputs (LSB-first byte order)
//   state_out           registered round result (LSB-first byte order)
module aes_round_engine
   import aes_pkg::*;
#(
   parameter int unsigned NR = AES_NR
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         next,
   input  logic [127:0] key_in,
   output logic [127:0] key_out,
   output logic [3:0]   round,
   input  logic         en,
   input  logic         skip_mixcols,
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   output logic [127:0] state_out
);

   logic [127:0] key_next;
   logic [7:0]   rcon_sel;
   logic         key_advance;

   logic [127:0] sub_bytes;
   logic [127:0] shift_rows;
   logic [127:0] mix_cols;
   logic [127:0] round_result;

   // Key schedule: expand from the currently held key.
   assign rcon_sel    = rcon(4'(round + 4'd1));
   assign key_advance = next && (round < 4'(NR));

   aes_key_step u_key_step (
      .key      (key_out),
      .rcon     (rcon_sel),
      .key_next (key_next)
   );

   // Key register: load wins over next; saturates at round NR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_out <= '0;
         round   <= '0;
      end else if (load) begin
         key_out <= key_in;
         round   <= '0;
      end else if (key_advance) begin
         key_out <= key_next;
         round   <= 4'(round + 4'd1);
      end
   end

   // Round datapath; byte i sits at row i%4, column i/4.
   always_comb begin
      sub_bytes  = '0;
      shift_rows = '0;
      mix_cols   = '0;
      for (int i = 0; i < 16; i++) begin
         sub_bytes[8*i +: 8] = sbox(state_in[8*i +: 8]);
      end
      // Row r of output column c comes from input column (c+r)%4.
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shift_rows[8*(r + 4*c) +: 8] = sub_bytes[8*(r + 4*((c + r) % 4)) +: 8];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mix_cols[32*c      +: 8] = gmul2(shift_rows[32*c +: 8]) ^ gmul3(shift_rows[32*c+8 +: 8])
                                    ^ shift_rows[32*c+16 +: 8] ^ shift_rows[32*c+24 +: 8];
         mix_cols[32*c + 8  +: 8] = shift_rows[32*c +: 8] ^ gmul2(shift_rows[32*c+8 +: 8])
                                    ^ gmul3(shift_rows[32*c+16 +: 8]) ^ shift_rows[32*c+24 +: 8];
         mix_cols[32*c + 16 +: 8] = shift_rows[32*c +: 8] ^ shift_rows[32*c+8 +: 8]
                                    ^ gmul2(shift_rows[32*c+16 +: 8]) ^ gmul3(shift_rows[32*c+24 +: 8]);
         mix_cols[32*c + 24 +: 8] = gmul3(shift_rows[32*c +: 8]) ^ shift_rows[32*c+8 +: 8]
                                    ^ shift_rows[32*c+16 +: 8] ^ gmul2(shift_rows[32*c+24 +: 8]);
      end
   end

   assign round_result = (skip_mixcols ? shift_rows : mix_cols) ^ round_key;

   // Round result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_out <= '0;
      end else if (en) begin
         state_out <= round_result;
      end
   end

`ifdef AES_TRACE_EN
   // Trace of key updates and enabled rounds, showing the values being captured.
   always @(posedge clk) begin
      if (rst_n && load) begin
         $display("[KEXP] r=%0d key=%h", 0, key_in);
      end else if (rst_n && key_advance) begin
         $display("[KEXP] r=%0d key=%h", 4'(round + 4'd1), key_next);
      end
      if (rst_n && en) begin
         $display("[RND] in=%h rk=%h out=%h skip=%b", state_in, round_key, round_result, skip_mixcols);
      end
   end
`endif

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed FIPS-197 vector bench for aes_round_engine.
module tb_aes_round_engine;

   logic         clk;
   logic         rst_n;
   logic         load;
   logic         next;
   logic [127:0] key_in;
   logic [127:0] key_out;
   logic [3:0]   round;
   logic         en;
   logic         skip_mixcols;
   logic [127:0] state_in;
   logic [127:0] round_key;
   logic [127:0] state_out;

   int vectors;
   int miscompares;

   localparam logic [127:0] KEY0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] KEY2   = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] KEY5   = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
   localparam logic [127:0] KEY10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] R1_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] R1_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
   localparam logic [127:0] R10_IN = 128'heb40f21e592e38848ba113e71bc342d2;
   localparam logic [127:0] R10_OUT= 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] ALT_KEY= 128'h000102030405060708090a0b0c0d0e0f;

   aes_round_engine dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load         (load),
      .next         (next),
      .key_in       (key_in),
      .key_out      (key_out),
      .round        (round),
      .en           (en),
      .skip_mixcols (skip_mixcols),
      .state_in     (state_in),
      .round_key    (round_key),
      .state_out    (state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] tb_bswap(input logic [127:0] x);
      logic [127:0] y;
      for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
      return y;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      vectors++;
      if (key_out !== 128'h0) begin
         $display("FAIL reset_key_out: got %h want %h", key_out, 128'h0); miscompares++;
      end
      vectors++;
      if (round !== 4'd0) begin
         $display("FAIL reset_round: got %0d want 0", round); miscompares++;
      end
      vectors++;
      if (state_out !== 128'h0) begin
         $display("FAIL reset_state_out: got %h want %h", state_out, 128'h0); miscompares++;
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_key_expand();
      key_in = KEY0; load = 1'b1;
      tick();
      load = 1'b0;
      vectors++;
      if (key_out !== KEY0 || round !== 4'd0) begin
         $display("FAIL key_load: got %h r=%0d want %h r=0", key_out, round, KEY0); miscompares++;
      end
      next = 1'b1;
      tick();
      next = 1'b0;
      vectors++;
      if (key_out !== KEY1) begin
         $display("FAIL key_r1: got %h want %h", key_out, KEY1); miscompares++;
      end
      vectors++;
      if (round !== 4'd1) begin
         $display("FAIL key_r1_round: got %0d want 1", round); miscompares++;
      end
      next = 1'b1;
      tick();
      next = 1'b0;
      vectors++;
      if (key_out !== KEY2 || round !== 4'd2) begin
         $display("FAIL key_r2: got %h r=%0d want %h r=2", key_out, round, KEY2); miscompares++;
      end
   endtask

   task automatic test_key_saturate();
      key_in = KEY0; load = 1'b1;
      tick();
      load = 1'b0; next = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      vectors++;
      if (key_out !== KEY10) begin
         $display("FAIL key_r10: got %h want %h", key_out, KEY10); miscompares++;
      end
      vectors++;
      if (round !== 4'd10) begin
         $display("FAIL key_r10_round: got %0d want 10", round); miscompares++;
      end
      tick();
      tick();
      next = 1'b0;
      vectors++;
      if (key_out !== KEY10) begin
         $display("FAIL key_hold: got %h want %h", key_out, KEY10); miscompares++;
      end
      vectors++;
      if (round !== 4'd10) begin
         $display("FAIL key_hold_round: got %0d want 10", round); miscompares++;
      end
   endtask

   task automatic test_round_full();
      en = 1'b1; skip_mixcols = 1'b0;
      state_in  = tb_bswap(R1_IN);
      round_key = tb_bswap(KEY1);
      tick();
      en = 1'b0;
      vectors++;
      if (state_out !== tb_bswap(R1_OUT)) begin
         $display("FAIL round_full: got %h want %h", state_out, tb_bswap(R1_OUT)); miscompares++;
      end
   endtask

   task automatic test_enable_hold();
      en = 1'b0;
      state_in  = {4{32'hdeadbeef}};
      round_key = {4{32'h12345678}};
      skip_mixcols = 1'b1;
      tick();
      state_in = {4{32'h0badf00d}};
      tick();
      vectors++;
      if (state_out !== tb_bswap(R1_OUT)) begin
         $display("FAIL enable_hold: got %h want %h", state_out, tb_bswap(R1_OUT)); miscompares++;
      end
   endtask

   task automatic test_round_final();
      en = 1'b1; skip_mixcols = 1'b1;
      state_in  = tb_bswap(R10_IN);
      round_key = tb_bswap(KEY10);
      tick();
      en = 1'b0; skip_mixcols = 1'b0;
      vectors++;
      if (state_out !== tb_bswap(R10_OUT)) begin
         $display("FAIL round_final: got %h want %h", state_out, tb_bswap(R10_OUT)); miscompares++;
      end
   endtask

   task automatic test_load_priority();
      key_in = ALT_KEY; load = 1'b1; next = 1'b1;
      tick();
      load = 1'b0; next = 1'b0;
      vectors++;
      if (round !== 4'd0) begin
         $display("FAIL load_prio_round: got %0d want 0", round); miscompares++;
      end
      vectors++;
      if (key_out !== ALT_KEY) begin
         $display("FAIL load_prio_key: got %h want %h", key_out, ALT_KEY); miscompares++;
      end
   endtask

   task automatic test_async_reset();
      key_in = KEY0; load = 1'b1;
      tick();
      load = 1'b0; next = 1'b1;
      en = 1'b1; skip_mixcols = 1'b0;
      state_in  = tb_bswap(R1_IN);
      round_key = tb_bswap(KEY1);
      for (int i = 0; i < 5; i++) tick();
      next = 1'b0; en = 1'b0;
      vectors++;
      if (round !== 4'd5 || key_out !== KEY5) begin
         $display("FAIL pre_reset_r5: got %h r=%0d want %h r=5", key_out, round, KEY5); miscompares++;
      end
      vectors++;
      if (state_out !== tb_bswap(R1_OUT)) begin
         $display("FAIL pre_reset_state: got %h want %h", state_out, tb_bswap(R1_OUT)); miscompares++;
      end
      // Mid-cycle, well before the next rising edge.
      #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (key_out !== 128'h0) begin
         $display("FAIL async_key_out: got %h want %h", key_out, 128'h0); miscompares++;
      end
      vectors++;
      if (round !== 4'd0) begin
         $display("FAIL async_round: got %0d want 0", round); miscompares++;
      end
      vectors++;
      if (state_out !== 128'h0) begin
         $display("FAIL async_state_out: got %h want %h", state_out, 128'h0); miscompares++;
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      rst_n        = 1'b0;
      load         = 1'b0;
      next         = 1'b0;
      key_in       = '0;
      en           = 1'b0;
      skip_mixcols = 1'b0;
      state_in     = '0;
      round_key    = '0;

      test_reset();
      test_key_expand();
      test_key_saturate();
      test_round_full();
      test_enable_hold();
      test_round_final();
      test_load_priority();
      test_async_reset();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
